// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter and related shared-resource arbiters.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam int STATS_WIDTH = 16;

  // Width-safe ceil(log2): never returns 0, so it can size a vector directly.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping, as one-hot plus index.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  int j;

  // NOTE: every output gets a default before the loop so no path leaves a value unassigned (no latch).
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!valid_o && req_i[j]) begin
        valid_o    = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ bursting requesters.
// Optional per-requester accepted-beat counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          WClk,
  input  logic                          Clear_in,
  input  logic [NUM_REQ-1:0]            Req_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] Data_in,
  input  logic [NUM_REQ-1:0]            Last_in,
  input  logic                          Full_in,
`ifdef FIFO_ARB_STATS_EN
  input  logic [clog2(NUM_REQ)-1:0]     Stats_sel_in,
  output logic [STATS_WIDTH-1:0]        Stats_out,
`endif
  output logic [NUM_REQ-1:0]            Grant_out,
  output logic [NUM_REQ-1:0]            Accept_out,
  output logic                          WriteEn_out,
  output logic [DATA_WIDTH-1:0]         Data_out
);

  localparam int IW = clog2(NUM_REQ);
  localparam int CW = clog2(MAX_BURST);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [CW-1:0]      count_q, count_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;
  logic [NUM_REQ-1:0] accept_vec;
  logic               beat_ok;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req_i   (Req_in),
    .ptr_i   (rr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge WClk) begin
    if (Clear_in) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      count_q <= count_d;
    end
  end

  assign beat_ok = Req_in[owner_q] & ~Full_in;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          grant_d = pick_grant;
          owner_d = pick_idx;
          count_d = '0;
        end
      end
      GRANT: begin
        // Full_in holds everything; an abandon only counts when the FIFO could have taken the beat.
        if ((beat_ok && (Last_in[owner_q] || count_q == CW'(MAX_BURST - 1))) ||
            (!Req_in[owner_q] && !Full_in)) begin
          state_d = IDLE;
          grant_d = '0;
          count_d = '0;
          rr_d    = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        end else if (beat_ok) begin
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept_vec  = grant_q & Req_in & {NUM_REQ{~Full_in}};
    Accept_out  = accept_vec;
    WriteEn_out = |accept_vec;
    Data_out    = '0;
    if (WriteEn_out) Data_out = Data_in[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
  end

  assign Grant_out = grant_q;

`ifdef FIFO_ARB_STATS_EN
  logic [STATS_WIDTH-1:0] stats_q [NUM_REQ];
  logic [STATS_WIDTH-1:0] stats_out_q;

  // NOTE: the counter array is reset on purpose: Clear_in defines their architectural value.
  always_ff @(posedge WClk) begin
    if (Clear_in) begin
      for (int i = 0; i < NUM_REQ; i++) stats_q[i] <= '0;
      stats_out_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept_vec[i] && stats_q[i] != '1) stats_q[i] <= stats_q[i] + 1'b1;
      end
      stats_out_q <= (int'(Stats_sel_in) < NUM_REQ) ? stats_q[Stats_sel_in] : '0;
    end
  end

  assign Stats_out = stats_out_q;
`endif

endmodule
